// File: rtl/jtag_conv_pkg.sv
// ============================================================================
//  Module      : jtag_conv_pkg
//  Description : Shared types and helpers for the JTAG TAP reset sequencer:
//                sequencer state encoding, minimum Test-Logic-Reset edge
//                count and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtag_conv_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      TLR_DRIVE = 2'd1,
      RTI_DRIVE = 2'd2,
      FINISH    = 2'd3
   } seq_state_t;

   // Five TMS=1 rising edges reach Test-Logic-Reset from any TAP state.
   localparam int JTAG_MIN_TLR_EDGES = 5;

   // Bits needed to hold values 0..max_val (never less than one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_tck_divider.sv
// ============================================================================
//  Module      : jtag_tck_divider
//  Description : Generates the sequencer's TCK by dividing clk_i. The divider
//                counts 0..TCK_DIV-1; at terminal count it wraps and tck
//                toggles. rise_o / fall_o flag the clk_i cycle whose edge
//                performs the 0->1 / 1->0 toggle.
//  Ports       : clk_i  - system clock
//                rst_i  - synchronous active-high reset
//                en_i   - advance the divider
//                clr_i  - synchronous clear (divider=0, tck=0), wins over en_i
//                tck_o  - registered divided clock
//                rise_o - tck toggles 0->1 at the coming clk_i edge
//                fall_o - tck toggles 1->0 at the coming clk_i edge
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_tck_divider
   import jtag_conv_pkg::*;
#(
   parameter int TCK_DIV = 12
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   output logic tck_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int               DIV_W    = cnt_width(TCK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             tck_q, tck_d;
   logic             term_w;

   assign term_w = en_i && !clr_i && (div_q == DIV_LAST);

   always_comb begin
      div_d = div_q;
      tck_d = tck_q;
      if (clr_i) begin
         div_d = '0;
         tck_d = 1'b0;
      end else if (en_i) begin
         if (term_w) begin
            div_d = '0;
            tck_d = ~tck_q;
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q <= '0;
         tck_q <= 1'b0;
      end else begin
         div_q <= div_d;
         tck_q <= tck_d;
      end
   end

   assign tck_o  = tck_q;
   assign rise_o = term_w && !tck_q;
   assign fall_o = term_w &&  tck_q;

endmodule

`default_nettype wire

// File: rtl/jtag_tap_reset_sequencer.sv
// ============================================================================
//  Module      : jtag_tap_reset_sequencer
//  Description : On a falling edge of the watchdog's RESET_REQ_N, takes over
//                the JTAG pins and clocks TMS=1 for TMS_HIGH_CYCLES TCK
//                rising edges (Test-Logic-Reset), then TMS=0 for RTI_CYCLES
//                edges (Run-Test/Idle). Otherwise the host bit engine's
//                TCK/TMS/TDI pass straight through.
//  Ports       : CLK, RST          - clock, synchronous active-high reset
//                RESET_REQ_N       - asynchronous active-low reset request
//                HOST_TCK/TMS/TDI  - host-side JTAG signals
//                TCK_OUT/TMS_OUT/TDI_OUT - JTAG pins
//                BUSY              - sequencer owns the pins
//                DONE              - one-CLK pulse at sequence completion
//                TRST_N            - only with JTAG_TAP_RESET_TRST_EN defined;
//                                    low throughout TLR_DRIVE
//  Options     : `define JTAG_TAP_RESET_TRST_EN adds the TRST_N output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_tap_reset_sequencer
   import jtag_conv_pkg::*;
#(
   parameter int TCK_DIV         = 12,
   parameter int TMS_HIGH_CYCLES = 8,
   parameter int RTI_CYCLES      = 1
) (
   input  logic CLK,
   input  logic RST,
   input  logic RESET_REQ_N,
   input  logic HOST_TCK,
   input  logic HOST_TMS,
   input  logic HOST_TDI,
   output logic TCK_OUT,
   output logic TMS_OUT,
   output logic TDI_OUT,
   output logic BUSY,
`ifdef JTAG_TAP_RESET_TRST_EN
   output logic TRST_N,
`endif
   output logic DONE
);

   // ------------------------------------------------------------------
   // Parameter legality
   // ------------------------------------------------------------------
   generate
      if (TCK_DIV < 1) begin : g_bad_tck_div
         $error("TCK_DIV must be >= 1");
      end
      if (TMS_HIGH_CYCLES < JTAG_MIN_TLR_EDGES) begin : g_bad_tms_high
         $error("TMS_HIGH_CYCLES must be >= JTAG_MIN_TLR_EDGES");
      end
      if (RTI_CYCLES < 1) begin : g_bad_rti
         $error("RTI_CYCLES must be >= 1");
      end
   endgenerate

   localparam int EDGE_MAX = (TMS_HIGH_CYCLES > RTI_CYCLES) ? TMS_HIGH_CYCLES : RTI_CYCLES;
   localparam int EDGE_W   = cnt_width(EDGE_MAX);
   localparam logic [EDGE_W-1:0] TLR_EDGES = EDGE_W'(TMS_HIGH_CYCLES);
   localparam logic [EDGE_W-1:0] RTI_EDGES = EDGE_W'(RTI_CYCLES);

   seq_state_t        state_q, state_d;
   logic              sync1_q, sync2_q, prev_q;
   logic              pending_q, pending_d;
   logic              tms_q, tms_d;
   logic [EDGE_W-1:0] edge_q, edge_d;
   logic              start_w, drive_w, tlr_done_w, rti_done_w;
   logic              tck_w, rise_w, fall_w;

   // Request synchronizer; start is a synchronized 1->0 transition, so a
   // request held low only ever triggers once.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= RESET_REQ_N;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign start_w = prev_q && !sync2_q;

   // TCK runs only in the driving states; held cleared (tck low) elsewhere,
   // which guarantees the pins are handed back with TCK low.
   assign drive_w = (state_q == TLR_DRIVE) || (state_q == RTI_DRIVE);

   jtag_tck_divider #(
      .TCK_DIV (TCK_DIV)
   ) u_tck_div (
      .clk_i  (CLK),
      .rst_i  (RST),
      .en_i   (drive_w),
      .clr_i  (!drive_w),
      .tck_o  (tck_w),
      .rise_o (rise_w),
      .fall_o (fall_w)
   );

   // Phase transitions happen only on falling toggles so TMS is stable
   // around every TCK rising edge.
   assign tlr_done_w = fall_w && (edge_q >= TLR_EDGES);
   assign rti_done_w = fall_w && (edge_q >= RTI_EDGES);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (start_w || pending_q) state_d = TLR_DRIVE;
         TLR_DRIVE: if (tlr_done_w)           state_d = RTI_DRIVE;
         RTI_DRIVE: if (rti_done_w)           state_d = FINISH;
         FINISH:                              state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath next values: pending flag, tms, edge counter
   // ------------------------------------------------------------------
   always_comb begin
      pending_d = pending_q;
      tms_d     = tms_q;
      edge_d    = edge_q;
      case (state_q)
         IDLE: begin
            // A fresh start or a queued one is consumed here.
            pending_d = 1'b0;
            tms_d     = 1'b1;
            edge_d    = '0;
         end
         TLR_DRIVE: begin
            if (start_w) pending_d = 1'b1;
            if (tlr_done_w) begin
               tms_d  = 1'b0;
               edge_d = '0;
            end else begin
               tms_d = 1'b1;
               if (rise_w) edge_d = edge_q + 1'b1;
            end
         end
         RTI_DRIVE: begin
            if (start_w) pending_d = 1'b1;
            tms_d = 1'b0;
            if (rise_w) edge_d = edge_q + 1'b1;
         end
         FINISH: begin
            if (start_w) pending_d = 1'b1;
            tms_d  = 1'b1;
            edge_d = '0;
         end
         default: begin
            pending_d = 1'b0;
            tms_d     = 1'b1;
            edge_d    = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pending_q <= 1'b0;
         tms_q     <= 1'b1;
         edge_q    <= '0;
      end else begin
         pending_q <= pending_d;
         tms_q     <= tms_d;
         edge_q    <= edge_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: outputs and pin mux
   // ------------------------------------------------------------------
   always_comb begin
      BUSY = (state_q != IDLE);
      DONE = (state_q == FINISH);
      if (state_q == IDLE) begin
         TCK_OUT = HOST_TCK;
         TMS_OUT = HOST_TMS;
         TDI_OUT = HOST_TDI;
      end else begin
         TCK_OUT = tck_w;
         TMS_OUT = tms_q;
         TDI_OUT = 1'b1;
      end
   end

`ifdef JTAG_TAP_RESET_TRST_EN
   assign TRST_N = (state_q != TLR_DRIVE);
`endif

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_reset_sequencer.sv
// ============================================================================
//  Module      : tb_jtag_tap_reset_sequencer
//  Description : Directed self-checking bench for jtag_tap_reset_sequencer
//                with TCK_DIV=4, TMS_HIGH_CYCLES=8, RTI_CYCLES=1.
//  Options     : JTAG_TAP_RESET_TRST_EN enables the TRST_N checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_tap_reset_sequencer;

   localparam int TCK_DIV  = 4;
   localparam int TMS_HIGH = 8;
   localparam int RTI      = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_n = 1'b1;
   logic host_tck = 1'b0;
   logic host_tms = 1'b0;
   logic host_tdi = 1'b0;
   logic tck_out, tms_out, tdi_out, busy, done;
`ifdef JTAG_TAP_RESET_TRST_EN
   logic trst_n;
`endif

   int errors = 0;
   int checks = 0;

   // Monitor state, written only by the monitor process.
   int   rise_cnt = 0;
   int   done_cnt = 0;
   int   trst_low_cnt = 0;
   logic tck_prev = 1'b0;
   logic tms_hist [0:1023];

   jtag_tap_reset_sequencer #(
      .TCK_DIV         (TCK_DIV),
      .TMS_HIGH_CYCLES (TMS_HIGH),
      .RTI_CYCLES      (RTI)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .RESET_REQ_N (req_n),
      .HOST_TCK    (host_tck),
      .HOST_TMS    (host_tms),
      .HOST_TDI    (host_tdi),
      .TCK_OUT     (tck_out),
      .TMS_OUT     (tms_out),
      .TDI_OUT     (tdi_out),
      .BUSY        (busy),
`ifdef JTAG_TAP_RESET_TRST_EN
      .TRST_N      (trst_n),
`endif
      .DONE        (done)
   );

   always #5 clk = ~clk;

   // Pin monitor sampled on the falling CLK edge.
   always @(negedge clk) begin
      if (tck_out && !tck_prev) begin
         if (rise_cnt < 1024) tms_hist[rise_cnt] = tms_out;
         rise_cnt = rise_cnt + 1;
      end
      tck_prev = tck_out;
      if (done) done_cnt = done_cnt + 1;
`ifdef JTAG_TAP_RESET_TRST_EN
      if (!trst_n) trst_low_cnt = trst_low_cnt + 1;
`endif
   end

   // IEEE 1149.1 TAP: 0 TLR,1 RTI,2 SelDR,3 CapDR,4 ShDR,5 Ex1DR,6 PDR,
   // 7 Ex2DR,8 UpDR,9 SelIR,10 CapIR,11 ShIR,12 Ex1IR,13 PIR,14 Ex2IR,15 UpIR
   function automatic int tap_next(input int s, input logic t);
      case (s)
         0:  return t ? 0  : 1;
         1:  return t ? 2  : 1;
         2:  return t ? 9  : 3;
         3:  return t ? 5  : 4;
         4:  return t ? 5  : 4;
         5:  return t ? 8  : 6;
         6:  return t ? 7  : 6;
         7:  return t ? 8  : 4;
         8:  return t ? 2  : 1;
         9:  return t ? 0  : 10;
         10: return t ? 12 : 11;
         11: return t ? 12 : 11;
         12: return t ? 15 : 13;
         13: return t ? 14 : 13;
         14: return t ? 15 : 11;
         15: return t ? 2  : 1;
         default: return 0;
      endcase
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_n = 1'b1;
      host_tck = 1'b1; host_tms = 1'b0; host_tdi = 1'b0;
      step(3);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
      checks++; if (tck_out !== 1'b1) begin errors++; $display("FAIL rst_tck_pass: got %b expected 1", tck_out); end
      checks++; if (tms_out !== 1'b0) begin errors++; $display("FAIL rst_tms_pass: got %b expected 0", tms_out); end
      checks++; if (tdi_out !== 1'b0) begin errors++; $display("FAIL rst_tdi_pass: got %b expected 0", tdi_out); end
`ifdef JTAG_TAP_RESET_TRST_EN
      checks++; if (trst_n !== 1'b1) begin errors++; $display("FAIL rst_trst: got %b expected 1", trst_n); end
`endif
      rst = 1'b0;
      host_tck = 1'b0;
      step(3);
   endtask

   task automatic test_basic();
      int   rb, db, tlb, blen, nr, tap, late_busy;
      logic last_done, last_tck, exp_tms;
      step(1);
      rb = rise_cnt; db = done_cnt; tlb = trst_low_cnt;
      req_n = 1'b0;
      step(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_edge1: got %b expected 0", busy); end
      step(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_edge2: got %b expected 0", busy); end
      step(1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_edge3: got %b expected 1", busy); end
      blen = 0; last_done = 1'b0; last_tck = 1'b1;
      for (int i = 0; i < 200 && busy === 1'b1; i++) begin
         blen++; last_done = done; last_tck = tck_out;
         step(1);
      end
      checks++; if (blen != 73) begin errors++; $display("FAIL busy_len: got %0d expected 73", blen); end
      checks++; if (last_done !== 1'b1) begin errors++; $display("FAIL done_last_cycle: got %b expected 1", last_done); end
      checks++; if (last_tck !== 1'b0) begin errors++; $display("FAIL tck_at_release: got %b expected 0", last_tck); end
      // Request stays low: no second sequence.
      late_busy = 0;
      for (int i = 0; i < 30; i++) begin
         if (busy === 1'b1) late_busy++;
         step(1);
      end
      checks++; if (late_busy != 0) begin errors++; $display("FAIL held_low_retrigger: got %0d busy cycles expected 0", late_busy); end
      nr = rise_cnt - rb;
      checks++; if (nr != 9) begin errors++; $display("FAIL rise_count: got %0d expected 9", nr); end
      checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL done_pulses: got %0d expected 1", done_cnt - db); end
      for (int i = 0; i < 9; i++) begin
         exp_tms = (i < 8) ? 1'b1 : 1'b0;
         checks++;
         if (tms_hist[rb + i] !== exp_tms) begin
            errors++; $display("FAIL tms_at_rise%0d: got %b expected %b", i, tms_hist[rb + i], exp_tms);
         end
      end
      tap = 4;  // Shift-DR
      for (int i = 0; i < nr && i < 64; i++) tap = tap_next(tap, tms_hist[rb + i]);
      checks++; if (tap != 1) begin errors++; $display("FAIL tap_state: got %0d expected 1 (Run-Test/Idle)", tap); end
`ifdef JTAG_TAP_RESET_TRST_EN
      checks++; if (trst_low_cnt - tlb != 64) begin errors++; $display("FAIL trst_low_cycles: got %0d expected 64", trst_low_cnt - tlb); end
`endif
      req_n = 1'b1;
      step(4);
   endtask

   task automatic test_passthrough();
      logic [2:0] v;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         host_tck = v[2]; host_tms = v[1]; host_tdi = v[0];
         #1;
         checks++; if (tck_out !== v[2]) begin errors++; $display("FAIL pass_tck v%0d: got %b expected %b", i, tck_out, v[2]); end
         checks++; if (tms_out !== v[1]) begin errors++; $display("FAIL pass_tms v%0d: got %b expected %b", i, tms_out, v[1]); end
         checks++; if (tdi_out !== v[0]) begin errors++; $display("FAIL pass_tdi v%0d: got %b expected %b", i, tdi_out, v[0]); end
         step(1);
      end
      host_tck = 1'b0; host_tms = 1'b0; host_tdi = 1'b0;
      step(1);
      req_n = 1'b0;
      step(3);   // busy cycle 1
      step(9);   // busy cycle 10: internal tck low, TLR phase
      host_tck = 1'b1; host_tms = 1'b0; host_tdi = 1'b0;
      #1;
      checks++; if (tck_out !== 1'b0) begin errors++; $display("FAIL busy_tck_c10: got %b expected 0", tck_out); end
      checks++; if (tms_out !== 1'b1) begin errors++; $display("FAIL busy_tms_c10: got %b expected 1", tms_out); end
      checks++; if (tdi_out !== 1'b1) begin errors++; $display("FAIL busy_tdi_c10: got %b expected 1", tdi_out); end
      step(4);   // busy cycle 14: internal tck high
      host_tck = 1'b0;
      #1;
      checks++; if (tck_out !== 1'b1) begin errors++; $display("FAIL busy_tck_c14: got %b expected 1", tck_out); end
      checks++; if (tdi_out !== 1'b1) begin errors++; $display("FAIL busy_tdi_c14: got %b expected 1", tdi_out); end
      for (int i = 0; i < 200 && busy === 1'b1; i++) step(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pass_seq_end: got %b expected 0", busy); end
      host_tck = 1'b0; host_tms = 1'b0; host_tdi = 1'b0;
      req_n = 1'b1;
      step(4);
   endtask

   task automatic test_back_to_back(input bit extra);
      int   rb, db, runs, blen;
      logic prev_busy;
      step(1);
      rb = rise_cnt; db = done_cnt; runs = 0; blen = 0; prev_busy = 1'b0;
      req_n = 1'b0;
      for (int s = 1; s <= 220; s++) begin
         step(1);
         if (busy === 1'b1 && !prev_busy) runs++;
         if (busy === 1'b1) blen++;
         prev_busy = busy;
         if (s == 7)           req_n = 1'b1;
         if (s == 22)          req_n = 1'b0;   // busy cycle 20
         if (extra && s == 32) req_n = 1'b1;
         if (extra && s == 42) req_n = 1'b0;
      end
      checks++; if (runs != 2) begin errors++; $display("FAIL b2b_runs x%0d: got %0d expected 2", extra, runs); end
      checks++; if (blen != 146) begin errors++; $display("FAIL b2b_busy_cycles x%0d: got %0d expected 146", extra, blen); end
      checks++; if (rise_cnt - rb != 18) begin errors++; $display("FAIL b2b_rises x%0d: got %0d expected 18", extra, rise_cnt - rb); end
      checks++; if (done_cnt - db != 2) begin errors++; $display("FAIL b2b_done x%0d: got %0d expected 2", extra, done_cnt - db); end
      req_n = 1'b1;
      step(4);
   endtask

   task automatic test_rst_mid();
      int db, busy_seen;
      step(1);
      db = done_cnt;
      host_tck = 1'b0; host_tms = 1'b0; host_tdi = 1'b0;
      req_n = 1'b0;
      for (int i = 0; i < 10 && busy !== 1'b1; i++) step(1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_start: got %b expected 1", busy); end
      step(29);  // busy cycle 30
      rst = 1'b1; req_n = 1'b1;
      step(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
      checks++; if (tms_out !== 1'b0) begin errors++; $display("FAIL rstmid_tms_pass: got %b expected 0", tms_out); end
      checks++; if (tdi_out !== 1'b0) begin errors++; $display("FAIL rstmid_tdi_pass: got %b expected 0", tdi_out); end
      checks++; if (tck_out !== 1'b0) begin errors++; $display("FAIL rstmid_tck_pass: got %b expected 0", tck_out); end
      rst = 1'b0;
      busy_seen = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (busy === 1'b1) busy_seen++;
      end
      checks++; if (busy_seen != 0) begin errors++; $display("FAIL rstmid_restart: got %0d busy cycles expected 0", busy_seen); end
      checks++; if (done_cnt - db != 0) begin errors++; $display("FAIL rstmid_done_seen: got %0d expected 0", done_cnt - db); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_passthrough();
      test_back_to_back(1'b0);
      test_back_to_back(1'b1);
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
